// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client round-robin front end for the SDRAM controller command port.
// Latency: grant -> command registered next cycle; write ack one cycle after the command handshake,
// read ack one cycle after c_rvalid. Backpressure: a command is held on c_* until c_ready.
// Periodic auto-refresh requests pre-empt client grants; postponed refreshes are counted.
// Ports: CLK/RST clock and async reset; m0_*/m1_* client request/ack/data;
// c_* controller command and read-return; refresh_overflow sticky flag.
module sdram_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int DATA_W         = 16,
  parameter int REFRESH_CYCLES = 2589,
  parameter int MAX_PENDING    = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              c_refresh,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_rvalid,
  input  logic [DATA_W-1:0] c_rdata,
  output logic              refresh_overflow
);

  localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int PND_W = $clog2(MAX_PENDING + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [PND_W-1:0] PND_MAX    = PND_W'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, REFRESH, ISSUE, WAIT_RD} state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [PND_W-1:0]  pending, pending_nxt;
  logic              overflow_nxt;
  logic              last_grant, last_grant_nxt;
  logic              grant, grant_nxt;       // client owning the in-flight command
  logic              c_valid_nxt, c_refresh_nxt, c_we_nxt;
  logic [ADDR_W-1:0] c_addr_nxt;
  logic [DATA_W-1:0] c_wdata_nxt;
  logic              m0_ack_nxt, m1_ack_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;

  logic tick, refresh_hs, elig0, elig1, sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      timer            <= TMR_RELOAD;
      pending          <= '0;
      refresh_overflow <= 1'b0;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      c_valid          <= 1'b0;
      c_refresh        <= 1'b0;
      c_we             <= 1'b0;
      c_addr           <= '0;
      c_wdata          <= '0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_rdata         <= '0;
      m1_rdata         <= '0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      pending          <= pending_nxt;
      refresh_overflow <= overflow_nxt;
      last_grant       <= last_grant_nxt;
      grant            <= grant_nxt;
      c_valid          <= c_valid_nxt;
      c_refresh        <= c_refresh_nxt;
      c_we             <= c_we_nxt;
      c_addr           <= c_addr_nxt;
      c_wdata          <= c_wdata_nxt;
      m0_ack           <= m0_ack_nxt;
      m1_ack           <= m1_ack_nxt;
      m0_rdata         <= m0_rdata_nxt;
      m1_rdata         <= m1_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    c_valid_nxt    = c_valid;
    c_refresh_nxt  = c_refresh;
    c_we_nxt       = c_we;
    c_addr_nxt     = c_addr;
    c_wdata_nxt    = c_wdata;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    pending_nxt    = pending;
    overflow_nxt   = refresh_overflow;

    tick       = (timer == '0);
    timer_nxt  = tick ? TMR_RELOAD : timer - 1'b1;
    refresh_hs = (state == REFRESH) && c_ready;

    // Expiry and handshake in the same cycle cancel out.
    if (tick && !refresh_hs) begin
      if (pending == PND_MAX) overflow_nxt = 1'b1;
      else                    pending_nxt  = pending + 1'b1;
    end else if (!tick && refresh_hs) begin
      pending_nxt = pending - 1'b1;
    end

    // A client still showing its ack is presenting the request that was
    // just completed, so it must not be granted again this cycle.
    elig0 = m0_req && !m0_ack;
    elig1 = m1_req && !m1_ack;
    sel   = elig1 && (!elig0 || !last_grant);

    case (state)
      IDLE: begin
        // A refresh coming due this very cycle already wins over clients,
        // so the refresh command appears exactly one period after reset.
        if (pending != '0 || tick) begin
          c_valid_nxt   = 1'b1;
          c_refresh_nxt = 1'b1;
          state_nxt     = REFRESH;
        end else if (elig0 || elig1) begin
          grant_nxt      = sel;
          last_grant_nxt = sel;
          c_valid_nxt    = 1'b1;
          c_refresh_nxt  = 1'b0;
          c_we_nxt       = sel ? m1_we    : m0_we;
          c_addr_nxt     = sel ? m1_addr  : m0_addr;
          c_wdata_nxt    = sel ? m1_wdata : m0_wdata;
          state_nxt      = ISSUE;
        end
      end
      REFRESH: begin
        if (c_ready) begin
          c_valid_nxt   = 1'b0;
          c_refresh_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      ISSUE: begin
        if (c_ready) begin
          c_valid_nxt = 1'b0;
          if (c_we) begin
            m0_ack_nxt = !grant;
            m1_ack_nxt = grant;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (c_rvalid) begin
          if (grant) begin
            m1_rdata_nxt = c_rdata;
            m1_ack_nxt   = 1'b1;
          end else begin
            m0_rdata_nxt = c_rdata;
            m0_ack_nxt   = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter.
// Expected commands and acks are queued when stimulus is applied and
// compared by a monitor when the arbiter produces them.
module tb_sdram_arbiter;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int RC     = 2589;
  localparam int MAXP   = 7;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              c_valid, c_refresh, c_we;
  logic              c_ready = 1'b0;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_rvalid = 1'b0;
  logic [DATA_W-1:0] c_rdata = '0;
  logic              refresh_overflow;

  always #5 CLK = ~CLK;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_CYCLES(RC), .MAX_PENDING(MAXP)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_refresh(c_refresh), .c_we(c_we),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .refresh_overflow(refresh_overflow)
  );

  typedef struct {
    logic              refresh;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct {
    int                id;
    logic              we;
    logic [DATA_W-1:0] rdata;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  cmd_t exp_cmd;
  ack_t exp_ack;

  int   vectors = 0, miscompares = 0;
  int   vld_cycles = 0, ack0_cnt = 0, ack1_cnt = 0, ref_hs = 0, first = 0;
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  bit   rd_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_ack(input int id, input logic [DATA_W-1:0] rd);
    check("ack_expected", ack_q.size() != 0, 1);
    if (ack_q.size() != 0) begin
      exp_ack = ack_q.pop_front();
      check("ack_client", id, exp_ack.id);
      if (!exp_ack.we) check("ack_rdata", rd, exp_ack.rdata);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the values
  // the DUT will act on at the next posedge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (c_valid) vld_cycles++;
      if (c_valid && c_ready) begin
        if (c_refresh) ref_hs++;
        check("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          exp_cmd = cmd_q.pop_front();
          check("cmd_refresh", c_refresh, exp_cmd.refresh);
          if (!exp_cmd.refresh) begin
            check("cmd_we", c_we, exp_cmd.we);
            check("cmd_addr", c_addr, exp_cmd.addr);
            if (exp_cmd.we) check("cmd_wdata", c_wdata, exp_cmd.wdata);
          end
        end
      end
      if (m0_ack || m1_ack) check("ack_exclusive", m0_ack && m1_ack, 0);
      if (m0_ack) begin
        ack0_cnt++;
        check("ack0_one_cycle", prev_ack0, 0);
        pop_ack(0, m0_rdata);
      end
      if (m1_ack) begin
        ack1_cnt++;
        check("ack1_one_cycle", prev_ack1, 0);
        pop_ack(1, m1_rdata);
      end
    end
    prev_ack0 = m0_ack;
    prev_ack1 = m1_ack;
  end

  task automatic wait_ack(input int id);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if ((id == 0 && m0_ack) || (id == 1 && m1_ack)) begin
        got = 1;
        break;
      end
    end
    check($sformatf("ack_wait_m%0d", id), got, 1);
  endtask

  task automatic client_xact(input int id, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
    @(posedge CLK); #1;
    if (id == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else         begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    wait_ack(id);
  endtask

  task automatic client_drop(input int id);
    @(posedge CLK); #1;
    if (id == 0) m0_req = 1'b0;
    else         m1_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (cmd_q.size() == 0 && ack_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("queues_drained", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; m0_req = 1'b0; m1_req = 1'b0; c_ready = 1'b0; c_rvalid = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_c_valid", c_valid, 0);
    check("rst_c_refresh", c_refresh, 0);
    check("rst_c_cmd", {c_we, c_addr, c_wdata}, 0);
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    check("rst_overflow", refresh_overflow, 0);
    RST = 1'b0;

    // First refresh timing; m0 request arrives as the refresh comes due
    for (int n = 1; n <= RC + 5; n++) begin
      @(posedge CLK); #1;
      if (n == RC - 1) begin
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h0ABCDE; m0_wdata = 16'h1357;
      end
      if (c_valid) begin
        first = n;
        break;
      end
    end
    check("first_refresh_cycle", first, RC);
    check("first_is_refresh", c_refresh, 1);
    check("overflow_after_first", refresh_overflow, 0);
    cmd_q.push_back('{1'b1, 1'b0, 22'h0, 16'h0});
    cmd_q.push_back('{1'b0, 1'b1, 22'h0ABCDE, 16'h1357});
    ack_q.push_back('{0, 1'b1, 16'h0});
    repeat (10) @(posedge CLK);
    #1;
    check("refresh_held", c_valid && c_refresh, 1);
    c_ready = 1'b1;
    wait_ack(0);
    client_drop(0);
    wait_drain(20);

    // Single m0 write
    do_reset();
    c_ready = 1'b1; vld_cycles = 0; ack0_cnt = 0; ack1_cnt = 0;
    cmd_q.push_back('{1'b0, 1'b1, 22'h000123, 16'hBEEF});
    ack_q.push_back('{0, 1'b1, 16'h0});
    client_xact(0, 1'b1, 22'h000123, 16'hBEEF);
    client_drop(0);
    wait_drain(20);
    repeat (3) @(posedge CLK);
    check("wr_valid_cycles", vld_cycles, 1);
    check("wr_ack0_count", ack0_cnt, 1);
    check("wr_ack1_count", ack1_cnt, 0);

    // c_rvalid while idle is ignored
    @(posedge CLK); #1 c_rvalid = 1'b1; c_rdata = 16'hDEAD;
    @(posedge CLK); #1 c_rvalid = 1'b0; c_rdata = 16'h0;
    repeat (2) @(posedge CLK);
    check("idle_rvalid_no_ack", ack0_cnt + ack1_cnt, 1);

    // m1 read with data returned 5 cycles after the command handshake
    cmd_q.push_back('{1'b0, 1'b0, 22'h3FFFFF, 16'h0});
    ack_q.push_back('{1, 1'b0, 16'hA5A5});
    fork
      begin
        client_xact(1, 1'b0, 22'h3FFFFF, 16'h0);
        client_drop(1);
      end
      begin
        rd_seen = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge CLK);
          if (c_valid && c_ready && !c_we) begin
            rd_seen = 1;
            break;
          end
        end
        check("rd_issued", rd_seen, 1);
        repeat (5) @(posedge CLK);
        #1 c_rvalid = 1'b1; c_rdata = 16'hA5A5;
        @(posedge CLK); #1 c_rvalid = 1'b0; c_rdata = 16'h0;
        check("rd_ack_next_cycle", m1_ack, 1);
        check("rd_m1_rdata", m1_rdata, 16'hA5A5);
        @(posedge CLK); #1;
        check("rd_ack_one_cycle", m1_ack, 0);
      end
    join
    wait_drain(20);
    repeat (3) @(posedge CLK);
    check("m1_rdata_hold", m1_rdata, 16'hA5A5);
    check("m0_rdata_untouched", m0_rdata, 16'h0);

    // Both clients streaming writes: grants alternate starting with m0
    do_reset();
    c_ready = 1'b1; ack0_cnt = 0; ack1_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cmd_q.push_back('{1'b0, 1'b1, ADDR_W'(32'h000100 + k), DATA_W'(32'h1000 + k)});
      ack_q.push_back('{0, 1'b1, 16'h0});
      cmd_q.push_back('{1'b0, 1'b1, ADDR_W'(32'h200200 + k), DATA_W'(32'h2000 + k)});
      ack_q.push_back('{1, 1'b1, 16'h0});
    end
    fork
      begin
        for (int k = 0; k < 3; k++) client_xact(0, 1'b1, ADDR_W'(32'h000100 + k), DATA_W'(32'h1000 + k));
        client_drop(0);
      end
      begin
        for (int k = 0; k < 3; k++) client_xact(1, 1'b1, ADDR_W'(32'h200200 + k), DATA_W'(32'h2000 + k));
        client_drop(1);
      end
    join
    wait_drain(20);
    check("rr_ack0_count", ack0_cnt, 3);
    check("rr_ack1_count", ack1_cnt, 3);

    // Refresh postponed 8 periods: saturation at 7 and sticky overflow
    do_reset();
    repeat (RC + 5) @(posedge CLK);
    #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'h155555; m0_wdata = 16'h5A5A;
    for (int k = 0; k < MAXP; k++) cmd_q.push_back('{1'b1, 1'b0, 22'h0, 16'h0});
    cmd_q.push_back('{1'b0, 1'b1, 22'h155555, 16'h5A5A});
    ack_q.push_back('{0, 1'b1, 16'h0});
    repeat (8 * RC - 2 - (RC + 5)) @(posedge CLK);
    #1;
    check("overflow_before_8th", refresh_overflow, 0);
    repeat (4) @(posedge CLK);
    #1;
    check("overflow_after_8th", refresh_overflow, 1);
    ref_hs = 0;
    c_ready = 1'b1;
    wait_ack(0);
    client_drop(0);
    wait_drain(50);
    check("saturated_refresh_count", ref_hs, MAXP);
    check("overflow_sticky", refresh_overflow, 1);

    // Reset while a command is held in ISSUE: c_valid drops immediately
    do_reset();
    @(posedge CLK); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h0000AA;
    repeat (3) @(posedge CLK);
    #1;
    check("issue_c_valid", c_valid, 1);
    #2 RST = 1'b1; m0_req = 1'b0;
    #1;
    check("async_rst_c_valid", c_valid, 0);

    // Reset while waiting for read data; a late c_rvalid produces no ack
    do_reset();
    c_ready = 1'b1; ack0_cnt = 0;
    cmd_q.push_back('{1'b0, 1'b0, 22'h0000AA, 16'h0});
    @(posedge CLK); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'h0000AA;
    wait_drain(20);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1; m0_req = 1'b0;
    #1;
    check("waitrd_rst_outputs", {c_valid, c_refresh, m0_ack, m1_ack, refresh_overflow}, 0);
    check("waitrd_rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge CLK); #1 RST = 1'b0;
    c_rvalid = 1'b1; c_rdata = 16'hFFFF;
    @(posedge CLK); #1 c_rvalid = 1'b0; c_rdata = 16'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("late_rvalid_no_ack", ack0_cnt, 0);
    check("late_rvalid_rdata", m0_rdata, 16'h0);

    check("cmd_q_empty", cmd_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
